// File: rtl/mine_generator.sv
// Mine map generator: on a level-start edge, clears a 16x16 map and places distinct mines inside the
// active grid using a free-running Galois LFSR. Optional PLACE timeout is enabled by MINE_GEN_TIMEOUT_EN.
module mine_generator #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level_enable,
  input  logic [4:0] button_num,
  input  logic [5:0] mines,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic       rd_mine,
  output logic       gen_busy,
  output logic       gen_done,
  output logic [5:0] mines_placed,
  output logic       gen_timeout
);

  typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;

  // An all-zero seed would lock the LFSR up.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  state_t      state_reg, state_next;
  logic        prev_en_reg;
  logic        start;
  logic [15:0] lfsr_reg;
  logic [4:0]  side_reg, side_cap;
  logic [5:0]  target_reg, target_cap;
  logic [8:0]  cells_cap;
  logic [5:0]  placed_reg;
  logic        rd_mine_reg;
  logic [3:0]  cand_x, cand_y;
  logic        accept;
  logic        timeout_hit;
  logic [15:0] map_row [16];

  assign start  = level_enable & ~prev_en_reg;
  assign cand_x = lfsr_reg[3:0];
  assign cand_y = lfsr_reg[7:4];

  always_comb begin
    side_cap  = (button_num > 5'd16) ? 5'd16 : button_num;
    cells_cap = 9'(side_cap) * 9'(side_cap);
    if (side_cap == 5'd0)
      target_cap = 6'd0;
    else if ({3'b000, mines} >= cells_cap)
      target_cap = 6'(cells_cap - 9'd1);
    else
      target_cap = mines;
  end

  // Unplaced candidates (occupied or off-grid) are simply skipped; the LFSR moves on next cycle.
  assign accept = (state_reg == PLACE) && !start && (placed_reg != target_reg) &&
                  ({1'b0, cand_x} < side_reg) && ({1'b0, cand_y} < side_reg) &&
                  !map_row[cand_y][cand_x];

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = CLEAR;
    end else begin
      case (state_reg)
        CLEAR:   state_next = (target_reg == 6'd0) ? DONE : PLACE;
        PLACE:   if ((placed_reg == target_reg) || timeout_hit) state_next = DONE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      prev_en_reg <= 1'b0;
      lfsr_reg    <= SEED_EFF;
      side_reg    <= 5'd0;
      target_reg  <= 6'd0;
      placed_reg  <= 6'd0;
      rd_mine_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      prev_en_reg <= level_enable;
      lfsr_reg    <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
      rd_mine_reg <= map_row[rd_y][rd_x];
      if (start) begin
        side_reg   <= side_cap;
        target_reg <= target_cap;
      end
      if (state_reg == CLEAR)
        placed_reg <= 6'd0;
      else if (accept)
        placed_reg <= placed_reg + 6'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_row
      logic [15:0] row_reg;
      always_ff @(posedge clk) begin
        if (rst || (state_reg == CLEAR))
          row_reg <= 16'h0000;
        else if (accept && (cand_y == 4'(gi)))
          row_reg[cand_x] <= 1'b1;
      end
      assign map_row[gi] = row_reg;
    end
  endgenerate

`ifdef MINE_GEN_TIMEOUT_EN
  logic [15:0] tcnt_reg;
  logic        timeout_reg;

  // Fires on the TIMEOUT_CYCLES-th PLACE cycle unless that cycle's placement meets the target.
  assign timeout_hit = (state_reg == PLACE) && (placed_reg != target_reg) &&
                       (tcnt_reg == 16'(TIMEOUT_CYCLES - 1)) &&
                       !(accept && ((placed_reg + 6'd1) == target_reg));

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_reg    <= 16'd0;
      timeout_reg <= 1'b0;
    end else if (state_reg == CLEAR) begin
      tcnt_reg    <= 16'd0;
      timeout_reg <= 1'b0;
    end else begin
      if (state_reg == PLACE) tcnt_reg <= tcnt_reg + 16'd1;
      if (timeout_hit) timeout_reg <= 1'b1;
    end
  end

  assign gen_timeout = timeout_reg;
`else
  // Constant false; TIMEOUT_CYCLES only matters in the timeout build.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign gen_timeout = 1'b0;
`endif

  assign rd_mine      = rd_mine_reg;
  assign gen_busy     = (state_reg == CLEAR) || (state_reg == PLACE);
  assign gen_done     = (state_reg == DONE);
  assign mines_placed = placed_reg;

endmodule

// File: tb/tb_mine_generator.sv
// Scoreboard bench for mine_generator: map reads are queued with expectations and checked by a
// separate monitor one cycle later; status outputs are checked directly after each run.
module tb_mine_generator;

`ifdef MINE_GEN_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 4096;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       level_enable = 1'b0;
  logic [4:0] button_num = 5'd0;
  logic [5:0] mines = 6'd0;
  logic [3:0] rd_x = 4'd0;
  logic [3:0] rd_y = 4'd0;
  logic       rd_mine;
  logic       gen_busy;
  logic       gen_done;
  logic [5:0] mines_placed;
  logic       gen_timeout;

  always #5 clk = ~clk;

  mine_generator #(.LFSR_SEED(16'hACE1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .level_enable(level_enable), .button_num(button_num),
    .mines(mines), .rd_x(rd_x), .rd_y(rd_y), .rd_mine(rd_mine), .gen_busy(gen_busy),
    .gen_done(gen_done), .mines_placed(mines_placed), .gen_timeout(gen_timeout)
  );

  typedef struct {
    bit       exact;
    bit       exp;
    bit [3:0] x;
    bit [3:0] y;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int      vectors = 0;
  int      miscompares = 0;
  int      ones_seen = 0;
  int      busy_rises = 0;
  logic    rd_issue = 1'b0;
  logic    vld_d = 1'b0;
  logic    busy_d = 1'b0;

  always @(posedge clk) vld_d <= rd_issue;

  // Read monitor: rd_mine is valid one cycle after the address was presented.
  always @(negedge clk) begin
    rd_exp_t e;
    if (vld_d) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_underflow: got a read response, required a queued expectation");
      end else begin
        e = sb_q.pop_front();
        if (e.exact) begin
          vectors++;
          if (rd_mine !== e.exp) begin
            miscompares++;
            $display("FAIL rd_cell x=%0d y=%0d: got %b required %b", e.x, e.y, rd_mine, e.exp);
          end
        end else if (rd_mine === 1'b1) begin
          ones_seen++;
        end
      end
    end
  end

  always @(negedge clk) begin
    busy_d <= gen_busy;
    if (gen_busy === 1'b1 && busy_d === 1'b0) busy_rises++;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Full 16x16 scan: off-grid cells must read 0, on-grid ones are counted.
  task automatic scan(input int side, input int exp_ones, input string name);
    rd_exp_t e;
    ones_seen = 0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        rd_x = 4'(x);
        rd_y = 4'(y);
        rd_issue = 1'b1;
        e.exact = (x >= side) || (y >= side);
        e.exp = 1'b0;
        e.x = 4'(x);
        e.y = 4'(y);
        sb_q.push_back(e);
        @(posedge clk); #1;
      end
    end
    rd_issue = 1'b0;
    @(negedge clk); #1;
    @(posedge clk); #1;
    check({name, "_drain"}, sb_q.size(), 0);
    check({name, "_ones"}, ones_seen, exp_ones);
    $display("scan %s: side=%0d ones=%0d", name, side, ones_seen);
  endtask

  task automatic start(input int bn, input int m, input int hold, input string name);
    button_num = 5'(bn);
    mines = 6'(m);
    level_enable = 1'b1;
    @(posedge clk); #1;
    button_num = 5'd3;
    mines = 6'd1;
    check({name, "_busy_n1"}, int'(gen_busy), 1);
    check({name, "_done_n1"}, int'(gen_done), 0);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
    end
    level_enable = 1'b0;
    $display("start %s: button_num=%0d mines=%0d hold=%0d", name, bn, m, hold);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (gen_done !== 1'b1 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done_reached"}, int'(gen_done === 1'b1), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy", int'(gen_busy), 0);
    check("reset_done", int'(gen_done), 0);
    check("reset_placed", int'(mines_placed), 0);
    check("reset_timeout", int'(gen_timeout), 0);
    check("reset_rd_mine", int'(rd_mine), 0);
    scan(0, 0, "reset");

`ifdef MINE_GEN_TIMEOUT_EN
    start(16, 50, 1, "timeout");
    wait_done("timeout");
    check("timeout_flag", int'(gen_timeout), 1);
    check("timeout_placed_le4", int'(mines_placed <= 6'd4), 1);
    start(8, 1, 1, "after_timeout");
    wait_done("after_timeout");
    check("after_timeout_flag", int'(gen_timeout), 0);
    check("after_timeout_placed", int'(mines_placed), 1);
`else
    busy_rises = 0;
    start(8, 8, 1, "level1");
    wait_done("level1");
    check("level1_placed", int'(mines_placed), 8);
    check("level1_busy", int'(gen_busy), 0);
    check("level1_timeout", int'(gen_timeout), 0);
    check("level1_runs", busy_rises, 1);
    scan(8, 8, "level1");

    start(8, 63, 1, "clamp63");
    wait_done("clamp63");
    check("clamp63_placed", int'(mines_placed), 63);
    scan(8, 63, "clamp63");

    start(31, 50, 1, "clamp_side");
    wait_done("clamp_side");
    check("clamp_side_placed", int'(mines_placed), 50);
    scan(16, 50, "clamp_side");

    start(0, 20, 1, "side0");
    @(posedge clk); #1;
    check("side0_done_n2", int'(gen_done), 1);
    check("side0_placed", int'(mines_placed), 0);
    scan(0, 0, "side0");

    start(8, 0, 1, "mines0");
    @(posedge clk); #1;
    check("mines0_done_n2", int'(gen_done), 1);
    check("mines0_placed", int'(mines_placed), 0);
    scan(0, 0, "mines0");

    start(16, 50, 1, "level3");
    repeat (8) @(posedge clk);
    #1;
    check("level3_midplace_busy", int'(gen_busy), 1);
    start(10, 20, 1, "restart");
    wait_done("restart");
    check("restart_placed", int'(mines_placed), 20);
    scan(10, 20, "restart");

    busy_rises = 0;
    start(8, 8, 10, "held");
    wait_done("held");
    repeat (5) @(posedge clk);
    #1;
    check("held_runs", busy_rises, 1);
    check("held_done", int'(gen_done), 1);
    check("held_placed", int'(mines_placed), 8);
    scan(8, 8, "held");

    start(16, 50, 1, "midreset");
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midreset_busy", int'(gen_busy), 0);
    check("midreset_done", int'(gen_done), 0);
    check("midreset_placed", int'(mines_placed), 0);
    check("midreset_rd_mine", int'(rd_mine), 0);
    scan(0, 0, "midreset");
    check("no_timeout_build", int'(gen_timeout), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
